// File: rtl/coupled_ram_arbiter.sv
// Round-robin arbiter sharing one single-port coupled RAM between the CPU (0) and NoC (1) ports.
// Define ARB_PERF_CNT_EN to add the grant/stall performance counters.
module coupled_ram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_lock,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*DATA_W/8-1:0] req_be,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]           perf_grants0,
    output logic [31:0]           perf_grants1,
    output logic [31:0]           perf_stall1,
`endif
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                win;
    logic                hs;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        req_ready  = '0;
        resp_valid = '0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_be     = '0;
        hs         = 1'b0;
        win        = req_valid[prio_q] ? prio_q : ~prio_q;

        case (state_q)
            IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                if (!rst && (|req_valid)) begin
                    hs             = 1'b1;
                    req_ready[win] = 1'b1;
                    gnt_d          = win;
                    we_d           = req_we[win];
                    addr_d         = win ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
                    wdata_d        = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    be_d           = win ? req_be[2*BE_W-1:BE_W]        : req_be[BE_W-1:0];
                    if (req_lock[win] && ((owner_q != win) || (cnt_q < CNT_W'(LOCK_MAX - 1)))) begin
                        prio_d  = win;
                        owner_d = win;
                        cnt_d   = (owner_q != win) ? CNT_W'(1) : cnt_q + 1'b1;
                    end else begin
                        prio_d  = ~win;
                        cnt_d   = '0;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                ram_be    = be_q;
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                rdata_d = we_q ? '0 : ram_rdata;
                state_d = RESP;
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                if (resp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    assign resp_rdata = rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] grants0_q, grants1_q, stall1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants0_q <= '0;
            grants1_q <= '0;
            stall1_q  <= '0;
        end else begin
            if (hs && !win) grants0_q <= grants0_q + 32'd1;
            if (hs && win)  grants1_q <= grants1_q + 32'd1;
            if (req_valid[1] && !req_ready[1]) stall1_q <= stall1_q + 32'd1;
        end
    end

    assign perf_grants0 = grants0_q;
    assign perf_grants1 = grants1_q;
    assign perf_stall1  = stall1_q;
`endif

endmodule

// File: tb/tb_coupled_ram_arbiter.sv
// Scoreboard bench for coupled_ram_arbiter: a behavioural RAM, a shadow memory model and
// a response queue filled on each request handshake and drained on each response handshake.
`timescale 1ns/1ps
module tb_coupled_ram_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 4;
    localparam int BE_W     = DATA_W / 8;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [1:0]            req_valid = '0;
    logic [1:0]            req_ready;
    logic [1:0]            req_we = '0;
    logic [1:0]            req_lock = '0;
    logic [2*ADDR_W-1:0]   req_addr = '0;
    logic [2*DATA_W-1:0]   req_wdata = '0;
    logic [2*BE_W-1:0]     req_be = '0;
    logic [1:0]            resp_valid;
    logic [1:0]            resp_ready = 2'b11;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [BE_W-1:0]       ram_be;
    logic [DATA_W-1:0]     ram_rdata = '0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]           perf_grants0, perf_grants1, perf_stall1;
`endif

    coupled_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_be(ram_be),
`ifdef ARB_PERF_CNT_EN
        .perf_grants0(perf_grants0), .perf_grants1(perf_grants1), .perf_stall1(perf_stall1),
`endif
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } txn_t;

    typedef struct {
        int                r;
        logic [DATA_W-1:0] d;
    } exp_t;

    txn_t              pend0[$];
    txn_t              pend1[$];
    exp_t              sb[$];
    int                glog[$];
    logic [DATA_W-1:0] last_rdata = '0;
    int                n_chk  = 0;
    int                n_fail = 0;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 3) return 32'hFFFFFFFF;
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic txn_t mk(input logic we, input logic lock, input int addr,
                                input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
        txn_t t;
        t.we = we; t.lock = lock; t.addr = ADDR_W'(addr); t.wdata = wdata; t.be = be;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Behavioural single-port RAM, read data one cycle after ram_en.
    logic [DATA_W-1:0] mem [DEPTH];
    bit                mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (ram_en) begin
            for (int b = 0; b < BE_W; b++)
                if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    // Monitor: shadow model predicts responses at request handshake; responses checked in order.
    logic [DATA_W-1:0] shadow [DEPTH];
    bit                sh_init = 1'b0;
    always @(negedge clk) begin
        if (!sh_init) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
            sh_init = 1'b1;
        end
        if (!rst) begin
            chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            chk("resp_valid_onehot0", 32'($onehot0(resp_valid)), 32'd1);
            for (int r = 0; r < 2; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    exp_t e;
                    logic [ADDR_W-1:0] a;
                    a   = req_addr[r*ADDR_W +: ADDR_W];
                    e.r = r;
                    e.d = req_we[r] ? '0 : shadow[a];
                    if (req_we[r])
                        for (int b = 0; b < BE_W; b++)
                            if (req_be[r*BE_W + b]) shadow[a][8*b +: 8] = req_wdata[r*DATA_W + 8*b +: 8];
                    sb.push_back(e);
                    glog.push_back(r);
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (resp_valid[r] && resp_ready[r]) begin
                    if (sb.size() == 0) begin
                        chk("resp_unexpected", 32'(r), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("resp_owner", 32'(r), 32'(e.r));
                        chk("resp_rdata", resp_rdata, e.d);
                        last_rdata = resp_rdata;
                    end
                end
            end
        end
    end

    task automatic drive_slot(input int r, input txn_t t);
        req_we[r]                     = t.we;
        req_lock[r]                   = t.lock;
        req_addr[r*ADDR_W +: ADDR_W]  = t.addr;
        req_wdata[r*DATA_W +: DATA_W] = t.wdata;
        req_be[r*BE_W +: BE_W]        = t.be;
        req_valid[r]                  = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 2'b11;
        sb.delete();
        glog.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents pending transactions of both requesters until all are accepted and answered.
    task automatic run_traffic(input int budget);
        int cyc = 0;
        logic [1:0] hs;
        while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && cyc < budget) begin
            if (pend0.size() > 0) drive_slot(0, pend0[0]); else req_valid[0] = 1'b0;
            if (pend1.size() > 0) drive_slot(1, pend1[0]); else req_valid[1] = 1'b0;
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (hs[0]) void'(pend0.pop_front());
            if (hs[1]) void'(pend1.pop_front());
            cyc++;
        end
        req_valid = '0;
        if (cyc >= budget) chk("traffic_timeout", 32'(cyc), 32'(budget - 1));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_ram_be"}, 32'(ram_be), 32'd0);
    endtask

    int exp_rr[8]   = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp_lock[8] = '{0, 1, 1, 1, 1, 0, 1, 1};

    initial begin
        #2;
        check_outputs_zero("reset");
        do_reset();

        // Single CPU read: ready at T, ram_en at T+1, response at T+3.
        drive_slot(0, mk(1'b0, 1'b0, 5, '0, '0));
        @(negedge clk);
        chk("lat_t0_req_ready", 32'(req_ready), 32'd1);
        chk("lat_t0_ram_en", 32'(ram_en), 32'd0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("lat_t1_ram_en", 32'(ram_en), 32'd1);
        chk("lat_t1_ram_addr", 32'(ram_addr), 32'd5);
        chk("lat_t1_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("lat_t2_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("lat_t3_resp_valid", 32'(resp_valid), 32'd1);
        chk("lat_t3_resp_rdata", resp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Round robin with both requesters continuously valid.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(mk(1'b0, 1'b0, 20 + i, '0, '0));
            pend1.push_back(mk(1'b0, 1'b0, 40 + i, '0, '0));
        end
        run_traffic(200);
        chk("rr_count", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(exp_rr[i]));

        // NoC locked burst against a waiting CPU.
        do_reset();
        for (int i = 0; i < 6; i++) pend1.push_back(mk(1'b0, 1'b1, 60 + i, '0, '0));
        for (int i = 0; i < 2; i++) pend0.push_back(mk(1'b0, 1'b0, 80 + i, '0, '0));
        run_traffic(200);
        chk("lock_count", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("lock_order", 32'(glog[i]), 32'(exp_lock[i]));

        // Partial byte write by the NoC, read back by the CPU.
        pend1.push_back(mk(1'b1, 1'b0, 3, 32'h12345678, 4'b0011));
        run_traffic(50);
        chk("wr_resp_zero", last_rdata, 32'd0);
        pend0.push_back(mk(1'b0, 1'b0, 3, '0, '0));
        run_traffic(50);
        chk("wr_merge", last_rdata, 32'hFFFF5678);

        // Response back-pressure with the CPU waiting.
        resp_ready[1] = 1'b0;
        drive_slot(1, mk(1'b0, 1'b0, 7, '0, '0));
        @(negedge clk);
        chk("stall_gnt", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drive_slot(0, mk(1'b0, 1'b0, 9, '0, '0));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", 32'(resp_valid), 32'd2);
            chk("stall_resp_rdata", resp_rdata, init_val(7));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_ram_en", 32'(ram_en), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready[1] = 1'b1;
        pend0.push_back(mk(1'b0, 1'b0, 9, '0, '0));
        run_traffic(50);
        chk("stall_cpu_after", last_rdata, init_val(9));

        // Reset in RESP with priority held by the NoC lock.
        pend0.push_back(mk(1'b0, 1'b0, 10, '0, '0));
        run_traffic(50);
        resp_ready[1] = 1'b0;
        drive_slot(1, mk(1'b0, 1'b1, 11, '0, '0));
        @(negedge clk);
        chk("rstresp_gnt", 32'(req_ready), 32'd2);
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
        chk("rstresp_in_resp", 32'(resp_valid), 32'd2);
        #1 rst = 1'b1;
        #1 check_outputs_zero("rstresp");
        sb.delete();
        glog.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 2'b11;
        drive_slot(0, mk(1'b0, 1'b0, 12, '0, '0));
        drive_slot(1, mk(1'b0, 1'b0, 13, '0, '0));
        @(negedge clk);
        chk("post_rst_first_gnt", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        pend1.push_back(mk(1'b0, 1'b0, 13, '0, '0));
        run_traffic(50);
        chk("post_rst_order_n", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) chk("post_rst_second", 32'(glog[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coupled_ram_arbiter.md
Name: coupled_ram_arbiter

Overview:
Shares one single-port coupled RAM of a mesh tile between two requesters: the local CPU data port (requester 0) and the NoC remote-access port (requester 1). Both requesters use a valid/ready request channel and a valid/ready response channel. The block sits between the CPU, the network interface and the coupled RAM in every tile of the XY mesh. It provides round-robin arbitration with a bounded lock for multi-flit NoC packets and enforces 1-cycle RAM read latency sequencing.

Parameters:
ADDR_W, 10, RAM word-address width
DATA_W, 32, data width (multiple of 8)
LOCK_MAX, 4, max consecutive grants one requester may hold via req_lock (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  2  request valid, bit r = requester r
req_ready  out  2  request accepted (one-hot or zero)
req_we  in  2  write enable per requester
req_lock  in  2  hold grant for the next transaction from the same requester
req_addr  in  2*ADDR_W  word address, slice r
req_wdata  in  2*DATA_W  write data, slice r
req_be  in  2*DATA_W/8  byte enables, slice r
resp_valid  out  2  response valid (one-hot or zero)
resp_ready  in  2  response accepted
resp_rdata  out  DATA_W  read data (0 for writes), shared by both requesters
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_be  out  DATA_W/8  RAM byte enables
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en

Behaviour:
- Reset (async, any time): state=IDLE, prio=0, lock_cnt=0, lock_owner=0. All outputs 0. An in-flight response is dropped. A RAM write already strobed is not undone.
- FSM: IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE. Only one transaction is in flight at a time.
- IDLE: winner = prio if req_valid[prio], else the other requester if it is valid. req_ready[winner]=1 combinationally. It is never asserted outside IDLE. On handshake, register we/addr/wdata/be, gnt<=winner, state ACCESS.
- ACCESS: ram_en=1 with the registered command for exactly one cycle -> CAPTURE.
- CAPTURE: sample ram_rdata into resp_rdata at the clock edge. For writes, resp_rdata<=0. Next state RESP.
- RESP: resp_valid[gnt]=1 and resp_rdata stable until resp_ready[gnt]. On that edge -> IDLE.
- Latency: request handshake at edge T, ram_en high in cycle T+1, resp_valid high from T+3. Minimum 4 cycles per transaction.
- Priority update at each request handshake:
  - If req_lock[winner]=1 and (lock_owner!=winner or lock_cnt<LOCK_MAX-1): prio<=winner, lock_owner<=winner, lock_cnt<=(owner changed ? 1 : lock_cnt+1).
  - Otherwise: prio<=~winner, lock_cnt<=0.
  - Consequence: one requester is never granted more than LOCK_MAX consecutive times while the other is waiting.
- Simultaneous valid with no lock: alternate 0,1,0,1 starting with 0 after reset.
- req_valid dropping before handshake is legal; the arbiter ignores it.
- The requester must hold its request fields stable while valid && !ready.
- Address and data are passed through unchanged; there is no bounds check.

Optional Feature:
ARB_PERF_CNT_EN:
- When defined, adds output ports perf_grants0, perf_grants1 and perf_stall1 (32 bits each).
  - perf_grants0 / perf_grants1: count request handshakes per requester.
  - perf_stall1: counts cycles with req_valid[1]=1 && !req_ready[1].
  - Counters wrap at 2^32, reset to 0 on rst, and are clear-free otherwise.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then CPU reads addr 5 (RAM[5]=0xDEADBEEF): req_ready[0] at T, ram_en at T+1, resp_valid[0] with 0xDEADBEEF at T+3.
- Both requesters hold valid, lock=0, 4 transactions each: grant order 0,1,0,1,... and each resp_valid goes only to its owner.
- NoC holds lock=1 with LOCK_MAX=4 while CPU is valid: NoC gets exactly 4 grants, then CPU is granted, then NoC resumes.
- NoC write be=4'b0011 data 0x12345678 to addr 3 (old 0xFFFFFFFF), then CPU read: resp_rdata=0xFFFF5678, and the write response has rdata 0.
- Hold resp_ready[1]=0 for 10 cycles: resp_valid[1] and resp_rdata stable, req_ready stays 0, ram_en stays 0.
- Assert rst during RESP: all outputs 0 immediately, and the next request after rst deasserts grants requester 0 first.
